// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory responder and its RAM.
package mem_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: one write port, one registered read.
// The read register clears on rst; the array contents are never cleared.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[adr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[adr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/memory_responder.sv
// Fixed-latency memory responder: IDLE -> ACCESS (LATENCY cycles) -> DONE.
// Optional MEM_LOADER_EN adds a preload port that writes the RAM while rst is high.
module memory_responder
  import mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] data_in,
`ifdef MEM_LOADER_EN
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_adr,
  input  logic [DATA_W-1:0] ld_data,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              mem_ready,
  output logic              busy,
  output logic              err
);
  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mem_ready_q, mem_ready_d;
  logic              err_q, err_d;
  logic              access;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    data_d      = data_q;
    mem_ready_d = 1'b0;
    err_d       = 1'b0;
    access      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_mem ^ wr_mem) begin
          op_d    = rd_mem ? OP_RD : OP_WR;
          adr_d   = adr;
          data_d  = data_in;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ACCESS;
        end else if (rd_mem && wr_mem) begin
          err_d = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          access      = 1'b1;
          mem_ready_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_RD;
      cnt_q       <= '0;
      adr_q       <= '0;
      data_q      <= '0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      adr_q       <= adr_d;
      data_q      <= data_d;
      mem_ready_q <= mem_ready_d;
      err_q       <= err_d;
    end
  end

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_wdata;

  // A CPU write is gated by rst so an aborted request never reaches the array.
`ifdef MEM_LOADER_EN
  logic ld_sel;
  assign ld_sel    = rst & ld_en;
  assign ram_we    = ld_sel | (access & (op_q == OP_WR) & ~rst);
  assign ram_adr   = ld_sel ? ld_adr  : adr_q;
  assign ram_wdata = ld_sel ? ld_data : data_q;
`else
  assign ram_we    = access & (op_q == OP_WR) & ~rst;
  assign ram_adr   = adr_q;
  assign ram_wdata = data_q;
`endif
  assign ram_re = access & (op_q == OP_RD);

  mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem_array (
    .clk    (clk),
    .rst    (rst),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .adr_i  (ram_adr),
    .wdata_i(ram_wdata),
    .rdata_o(data_out)
  );

  assign mem_ready = mem_ready_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (LATENCY 1, 3, 4) against a transaction-level model.
`timescale 1ns/1ps
module tb_memory_responder;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       [NI];
  logic       rd_mem    [NI];
  logic       wr_mem    [NI];
  logic [5:0] adr       [NI];
  logic [7:0] data_in   [NI];
  logic [7:0] data_out  [NI];
  logic       mem_ready [NI];
  logic       busy      [NI];
  logic       err       [NI];
`ifdef MEM_LOADER_EN
  logic       ld_en     [NI];
  logic [5:0] ld_adr    [NI];
  logic [7:0] ld_data   [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    memory_responder #(
      .DATA_W (8),
      .ADDR_W (6),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .rd_mem   (rd_mem[g]),
      .wr_mem   (wr_mem[g]),
      .adr      (adr[g]),
      .data_in  (data_in[g]),
`ifdef MEM_LOADER_EN
      .ld_en    (ld_en[g]),
      .ld_adr   (ld_adr[g]),
      .ld_data  (ld_data[g]),
`endif
      .data_out (data_out[g]),
      .mem_ready(mem_ready[g]),
      .busy     (busy[g]),
      .err      (err[g])
    );
  end

  // Reference model: word store per instance plus the expected read register.
  int         lat_m      [NI] = '{1, 3, 4};
  logic [7:0] mem_m      [NI][64];
  bit         wr_m       [NI][64];
  logic [7:0] dout_m     [NI];
  bit         dout_known [NI];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One request on instance g, checking every cycle until it returns to IDLE.
  // poke_at > 0 drives a stray request during that busy cycle; it must be ignored.
  task automatic txn(input int g, input bit rd, input bit wr, input logic [5:0] a,
                     input logic [7:0] d, input int poke_at);
    int L;
    int k;
    L = lat_m[g];
    rd_mem[g] = rd; wr_mem[g] = wr; adr[g] = a; data_in[g] = d;
    @(negedge clk);
    rd_mem[g] = 1'b0; wr_mem[g] = 1'b0;
    adr[g] = 6'($urandom); data_in[g] = 8'($urandom);
    if (rd && wr) begin
      chk("err_pulse", 32'(err[g]), 32'd1);
      chk("err_busy", 32'(busy[g]), 32'd0);
      chk("err_rdy", 32'(mem_ready[g]), 32'd0);
      @(negedge clk);
      chk("err_clear", 32'(err[g]), 32'd0);
      chk("err_rdy2", 32'(mem_ready[g]), 32'd0);
      if (dout_known[g]) chk("err_dout", 32'(data_out[g]), 32'(dout_m[g]));
      return;
    end
    for (int n = 1; n <= L + 1; n++) begin
      if (n > 1) @(negedge clk);
      rd_mem[g] = 1'b0; wr_mem[g] = 1'b0;
      chk("busy", 32'(busy[g]), 32'd1);
      chk("rdy", 32'(mem_ready[g]), 32'(n == L + 1));
      if (n == L + 1) begin
        if (rd) begin
          dout_known[g] = wr_m[g][a];
          dout_m[g]     = mem_m[g][a];
        end else begin
          mem_m[g][a] = d;
          wr_m[g][a]  = 1'b1;
        end
        if (dout_known[g]) chk("dout", 32'(data_out[g]), 32'(dout_m[g]));
      end
      if (n == poke_at) begin
        k = $urandom_range(0, 2);
        rd_mem[g]  = (k != 1);
        wr_mem[g]  = (k != 0);
        adr[g]     = 6'($urandom);
        data_in[g] = 8'($urandom);
      end
    end
    @(negedge clk);
    rd_mem[g] = 1'b0; wr_mem[g] = 1'b0;
    chk("idle_busy", 32'(busy[g]), 32'd0);
    chk("idle_rdy", 32'(mem_ready[g]), 32'd0);
    chk("idle_err", 32'(err[g]), 32'd0);
  endtask

  initial begin
    int g;
    int k;
    logic [5:0] a;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; rd_mem[i] = 1'b0; wr_mem[i] = 1'b0; adr[i] = '0; data_in[i] = '0;
`ifdef MEM_LOADER_EN
      ld_en[i] = 1'b0; ld_adr[i] = '0; ld_data[i] = '0;
`endif
      dout_m[i] = 8'h00; dout_known[i] = 1'b1;
      for (int j = 0; j < 64; j++) begin wr_m[i][j] = 1'b0; mem_m[i][j] = 8'h00; end
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_dout", 32'(data_out[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_rdy", 32'(mem_ready[i]), 32'd0);
      chk("rst_err", 32'(err[i]), 32'd0);
      rst[i] = 1'b0;
    end

    // Directed: write/read 0x05 at LATENCY=1, hold check, error case.
    txn(0, 1'b0, 1'b1, 6'h05, 8'h3C, 0);
    txn(0, 1'b1, 1'b0, 6'h05, 8'h00, 0);
    repeat (10) @(negedge clk);
    chk("dout_hold", 32'(data_out[0]), 32'h3C);
    txn(0, 1'b1, 1'b1, 6'h05, 8'hEE, 0);
    txn(0, 1'b1, 1'b0, 6'h05, 8'h00, 0);
    chk("err_nowrite", 32'(data_out[0]), 32'h3C);

    // LATENCY=4 with a stray read two edges after acceptance.
    txn(2, 1'b0, 1'b1, 6'h05, 8'h3C, 0);
    txn(2, 1'b1, 1'b0, 6'h05, 8'h00, 2);

    // LATENCY=3: reset during ACCESS drops the pending write.
    txn(1, 1'b0, 1'b1, 6'h3F, 8'h11, 0);
    txn(1, 1'b1, 1'b0, 6'h3F, 8'h00, 0);
    wr_mem[1] = 1'b1; adr[1] = 6'h3F; data_in[1] = 8'hAA;
    @(negedge clk);
    wr_mem[1] = 1'b0;
    @(negedge clk);
    chk("abort_busy_pre", 32'(busy[1]), 32'd1);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("abort_dout", 32'(data_out[1]), 32'd0);
    chk("abort_busy", 32'(busy[1]), 32'd0);
    dout_m[1] = 8'h00; dout_known[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_rdy", 32'(mem_ready[1]), 32'd0);
    end
    txn(1, 1'b1, 1'b0, 6'h3F, 8'h00, 0);
    chk("abort_keep", 32'(data_out[1]), 32'h11);

`ifdef MEM_LOADER_EN
    rst[0] = 1'b1; ld_en[0] = 1'b1; ld_adr[0] = 6'h00; ld_data[0] = 8'h81;
    @(negedge clk);
    ld_en[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    mem_m[0][0] = 8'h81; wr_m[0][0] = 1'b1; dout_m[0] = 8'h00; dout_known[0] = 1'b1;
    txn(0, 1'b1, 1'b0, 6'h00, 8'h00, 0);
    ld_en[0] = 1'b1; ld_data[0] = 8'h55;
    @(negedge clk);
    ld_en[0] = 1'b0;
    txn(0, 1'b1, 1'b0, 6'h00, 8'h00, 0);
    chk("ld_ignored", 32'(data_out[0]), 32'h81);
`endif

    // Preload a small address window, then random traffic over it.
    for (int i = 0; i < NI; i++)
      for (int j = 0; j < 8; j++)
        txn(i, 1'b0, 1'b1, 6'(j), 8'($urandom), 0);
    for (int it = 0; it < 80; it++) begin
      g = $urandom_range(0, NI - 1);
      k = $urandom_range(0, 9);
      a = 6'($urandom_range(0, 7));
      txn(g, (k >= 4), (k < 4) || (k >= 8), a, 8'($urandom),
          $urandom_range(0, lat_m[g] + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter DATA_W, default 8, data word width (2-bit opcode + 6-bit address field).
REQ-002 Parameter ADDR_W, default 6, address width; depth = 2**ADDR_W words.
REQ-003 Parameter LATENCY, default 1, ACCESS cycles per request; legal range 1..4.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rd_mem  input  1  read request, sampled only in IDLE.
REQ-007 wr_mem  input  1  write request, sampled only in IDLE.
REQ-008 adr  input  ADDR_W  request address.
REQ-009 data_in  input  DATA_W  write data (accumulator value).
REQ-010 data_out  output  DATA_W  registered read data; holds until next completed read.
REQ-011 mem_ready  output  1  one-cycle pulse in DONE; marks read data valid or write committed.
REQ-012 busy  output  1  high in ACCESS and DONE.
REQ-013 err  output  1  one-cycle pulse when rd_mem and wr_mem are both high while IDLE.

Function
REQ-014 FSM states: IDLE, ACCESS, DONE.
REQ-015 IDLE with exactly one of rd_mem or wr_mem high: latch adr, data_in, and op; load latency counter with LATENCY-1; go to ACCESS.
REQ-016 ACCESS: decrement counter each cycle; at count 0, perform the access and go to DONE.
REQ-017 Read: on the ACCESS->DONE edge, data_out <= mem[latched adr].
REQ-018 Write: on the ACCESS->DONE edge, mem[latched adr] <= latched data; data_out is unchanged.
REQ-019 DONE: mem_ready=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-020 Latency: request sampled at edge T -> mem_ready high during cycle T+LATENCY+1; back-to-back requests are accepted no sooner than edge T+LATENCY+2.
REQ-021 Requests while busy are ignored and not queued; latched adr and data are immune to input changes.
REQ-022 rd_mem and wr_mem both high in IDLE: err pulse next cycle, no memory access, state stays IDLE.
REQ-023 Address arithmetic: no wrap and no bounds check; every ADDR_W value is a valid word.
REQ-024 Read of a never-written word returns its array content (X in simulation); the bench does not check it.

Reset
REQ-025 rst high: state <= IDLE, counter <= 0, data_out <= 0, mem_ready <= 0, err <= 0; busy=0.
REQ-026 rst asserted mid-operation aborts the request; a pending write is dropped; the memory array is never cleared by reset.
REQ-027 First request is sampled on the first rising edge with rst low.

Configuration
REQ-028 Macro MEM_LOADER_EN: when defined, adds ports ld_en (in, 1), ld_adr (in, ADDR_W), ld_data (in, DATA_W).
REQ-029 With MEM_LOADER_EN: mem[ld_adr] <= ld_data on edges where ld_en=1 and rst=1 (program preload while the CPU is held in reset); ld_en with rst low is ignored.
REQ-030 Without MEM_LOADER_EN: no loader ports; the array is written only by CPU writes.

Structure
REQ-031 Package mem_pkg holds the state enum (IDLE/ACCESS/DONE), the op enum (OP_RD/OP_WR), and the DATA_W/ADDR_W defaults.
REQ-032 Sub-module mem_array: single-port synchronous RAM with one write port and one registered read, instantiated once; loader writes are muxed onto its port.

Verification
REQ-033 Reset, then wr_mem=1, adr=6'h05, data_in=8'h3C for 1 cycle -> mem_ready pulse at T+2 (LATENCY=1); busy high for 2 cycles.
REQ-034 Then rd_mem=1, adr=6'h05 -> data_out=8'h3C with mem_ready at T+2; data_out still 8'h3C 10 cycles later.
REQ-035 LATENCY=4: rd_mem at edge T -> mem_ready exactly at T+5; rd_mem pulsed at T+2 is ignored, with no second mem_ready.
REQ-036 rd_mem=1 and wr_mem=1 together, adr=6'h05 -> err pulse 1 cycle, no mem_ready, mem[5] unchanged (read back 8'h3C).
REQ-037 wr_mem adr=6'h3F data_in=8'hAA, rst pulsed in ACCESS (LATENCY=3) -> data_out=0, no mem_ready, mem[3F] not 8'hAA.
REQ-038 MEM_LOADER_EN: rst=1, ld_en writes 8'h81 to 6'h00 -> after reset release, rd adr 6'h00 returns 8'h81; ld_en with rst=0 leaves the word unchanged.
